// File: rtl/overcooked_pkg.sv
// Shared sprite-code definitions for the player controllers: direction codes,
// renderer state codes, held-item codes and the animation FSM states.
package overcooked_pkg;

    localparam logic [1:0] P_LEFT  = 2'd0;
    localparam logic [1:0] P_RIGHT = 2'd1;
    localparam logic [1:0] P_UP    = 2'd2;
    localparam logic [1:0] P_DOWN  = 2'd3;

    typedef logic [3:0] player_state_t;

    localparam player_state_t P_NOTHING       = 4'd0;
    localparam player_state_t P_CHOPPING      = 4'd1;
    localparam player_state_t P_ONION_WHOLE   = 4'd2;
    localparam player_state_t P_ONION_CHOPPED = 4'd3;
    localparam player_state_t P_POT_EMPTY     = 4'd4;
    localparam player_state_t P_POT_SOUP      = 4'd5;
    localparam player_state_t P_BOWL_EMPTY    = 4'd6;
    localparam player_state_t P_BOWL_FULL     = 4'd7;
    localparam player_state_t P_EXT_OFF       = 4'd8;
    localparam player_state_t P_EXT_ON        = 4'd9;

    typedef enum logic [3:0] {
        HELD_NOTHING       = 4'd0,
        HELD_ONION_WHOLE   = 4'd2,
        HELD_ONION_CHOPPED = 4'd3,
        HELD_POT_EMPTY     = 4'd4,
        HELD_POT_SOUP      = 4'd5,
        HELD_BOWL_EMPTY    = 4'd6,
        HELD_BOWL_FULL     = 4'd7,
        HELD_EXTINGUISHER  = 4'd8
    } held_item_e;

    typedef enum logic [1:0] {
        ANIM_IDLE  = 2'd0,
        ANIM_CHOP  = 2'd1,
        ANIM_SPRAY = 2'd2
    } anim_state_e;

    // Held items share the renderer encoding; codes the renderer reserves
    // for animation poses (1, 9) or leaves undefined collapse to NOTHING.
    function automatic player_state_t held_to_state(input logic [3:0] held);
        player_state_t code;
        case (held)
            4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: code = held;
            default: code = P_NOTHING;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/frame_commit_gen.sv
// Frame-boundary strobe shared by the sprite controllers: high for the single
// pixel clock where the raster sits at the start of the first blanking line.
module frame_commit_gen #(
    parameter int COMMIT_LINE = 768
) (
    input  logic [10:0] hcount_i,
    input  logic [9:0]  vcount_i,
    output logic        commit_o
);

    assign commit_o = (hcount_i == 11'd0) && (vcount_i == 10'(COMMIT_LINE));

endmodule

// File: rtl/player_anim_ctrl.sv
// Player sprite sequencer: maps game-logic requests to state/direction codes
// and commits them once per frame. Define PLAYER_ANIM_CHOP_PROGRESS_EN to add chop_progress_out.
module player_anim_ctrl
    import overcooked_pkg::*;
#(
    parameter int CHOP_FRAMES  = 8,
    parameter int CHOP_STROKES = 6,
    parameter int COMMIT_LINE  = 768
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        move_valid_in,
    input  logic [1:0]  move_dir_in,
    input  logic [3:0]  held_item_in,
    input  logic        chop_req_in,
    input  logic        spray_in,
    output logic [1:0]  player_direction_out,
    output logic [3:0]  player_state_out,
    output logic        chop_done_out,
    output logic        frame_commit_out
`ifdef PLAYER_ANIM_CHOP_PROGRESS_EN
    ,
    output logic [3:0]  chop_progress_out
`endif
);

    localparam int FCW = (CHOP_FRAMES > 1) ? $clog2(CHOP_FRAMES) : 1;
    localparam int SCW = (CHOP_STROKES > 0) ? $clog2(CHOP_STROKES + 1) : 1;

    localparam logic [FCW-1:0] FRAME_LAST  = FCW'(CHOP_FRAMES - 1);
    localparam logic [SCW-1:0] STROKE_LAST = SCW'(CHOP_STROKES - 1);
    localparam logic [FCW-1:0] FRAME_ZERO  = {FCW{1'b0}};
    localparam logic [SCW-1:0] STROKE_ZERO = {SCW{1'b0}};

    anim_state_e   state_q, state_d;
    logic          chopping_q, chopping_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [SCW-1:0] stroke_cnt_q, stroke_cnt_d;
    logic [1:0]    shadow_dir_q, shadow_dir_d;
    logic [1:0]    dir_q, dir_d;
    player_state_t code_q, code_d;

    logic          commit_s;
    logic          abort_s;
    logic          done_s;
    logic [1:0]    commit_dir_s;

    frame_commit_gen #(
        .COMMIT_LINE (COMMIT_LINE)
    ) u_frame_commit_gen (
        .hcount_i (hcount_in),
        .vcount_i (vcount_in),
        .commit_o (commit_s)
    );

    // A move arriving on the commit cycle itself must still reach the sprite.
    assign commit_dir_s = move_valid_in ? move_dir_in : shadow_dir_q;
    assign abort_s      = (state_q == ANIM_CHOP) && (!chop_req_in || move_valid_in);

    // Direction shadow and committed direction.
    always_comb begin
        shadow_dir_d = shadow_dir_q;
        dir_d        = dir_q;
        if (move_valid_in) begin
            shadow_dir_d = move_dir_in;
        end else begin
            shadow_dir_d = shadow_dir_q;
        end
        if (commit_s) begin
            dir_d = commit_dir_s;
        end else begin
            dir_d = dir_q;
        end
    end

    // Animation FSM next state, counters and the code to commit.
    always_comb begin
        state_d      = state_q;
        chopping_d   = chopping_q;
        frame_cnt_d  = frame_cnt_q;
        stroke_cnt_d = stroke_cnt_q;
        code_d       = code_q;
        done_s       = 1'b0;
        case (state_q)
            ANIM_IDLE: begin
                if (commit_s) begin
                    code_d = held_to_state(held_item_in);
                    if (chop_req_in && (held_item_in == HELD_NOTHING)) begin
                        state_d      = ANIM_CHOP;
                        chopping_d   = 1'b1;
                        frame_cnt_d  = FRAME_ZERO;
                        stroke_cnt_d = STROKE_ZERO;
                    end else if ((held_item_in == HELD_EXTINGUISHER) && spray_in) begin
                        state_d = ANIM_SPRAY;
                    end else begin
                        state_d = ANIM_IDLE;
                    end
                end else begin
                    state_d = ANIM_IDLE;
                end
            end
            ANIM_CHOP: begin
                // Abort takes priority over a stroke finishing on the same cycle.
                if (abort_s) begin
                    state_d      = ANIM_IDLE;
                    chopping_d   = 1'b0;
                    frame_cnt_d  = FRAME_ZERO;
                    stroke_cnt_d = STROKE_ZERO;
                    if (commit_s) begin
                        code_d = held_to_state(held_item_in);
                    end else begin
                        code_d = code_q;
                    end
                end else if (commit_s) begin
                    code_d = chopping_q ? P_CHOPPING : P_NOTHING;
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = FRAME_ZERO;
                        if (chopping_q) begin
                            chopping_d = 1'b0;
                        end else if (stroke_cnt_q == STROKE_LAST) begin
                            done_s       = 1'b1;
                            state_d      = ANIM_IDLE;
                            stroke_cnt_d = STROKE_ZERO;
                            code_d       = held_to_state(held_item_in);
                        end else begin
                            stroke_cnt_d = stroke_cnt_q + 1'b1;
                            chopping_d   = 1'b1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ANIM_CHOP;
                end
            end
            ANIM_SPRAY: begin
                if (commit_s) begin
                    code_d = P_EXT_ON;
                    if (!spray_in || (held_item_in != HELD_EXTINGUISHER)) begin
                        state_d = ANIM_IDLE;
                    end else begin
                        state_d = ANIM_SPRAY;
                    end
                end else begin
                    state_d = ANIM_SPRAY;
                end
            end
            default: begin
                state_d      = ANIM_IDLE;
                chopping_d   = 1'b0;
                frame_cnt_d  = FRAME_ZERO;
                stroke_cnt_d = STROKE_ZERO;
            end
        endcase
    end

    // State, counter and committed-output registers.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ANIM_IDLE;
            chopping_q   <= 1'b0;
            frame_cnt_q  <= FRAME_ZERO;
            stroke_cnt_q <= STROKE_ZERO;
            shadow_dir_q <= P_DOWN;
            dir_q        <= P_DOWN;
            code_q       <= P_NOTHING;
        end else begin
            state_q      <= state_d;
            chopping_q   <= chopping_d;
            frame_cnt_q  <= frame_cnt_d;
            stroke_cnt_q <= stroke_cnt_d;
            shadow_dir_q <= shadow_dir_d;
            dir_q        <= dir_d;
            code_q       <= code_d;
        end
    end

    assign player_direction_out = dir_q;
    assign player_state_out     = code_q;
    assign chop_done_out        = done_s;
    assign frame_commit_out     = commit_s;

`ifdef PLAYER_ANIM_CHOP_PROGRESS_EN
    logic [3:0] progress_q, progress_d;

    // Fraction of strokes done scaled to 0..15 for the progress bar.
    function automatic logic [3:0] stroke_progress(input logic [SCW-1:0] strokes);
        int scaled;
        scaled = (int'(strokes) * 16) / CHOP_STROKES;
        if (scaled > 15) begin
            return 4'd15;
        end else begin
            return 4'(scaled);
        end
    endfunction

    // Progress follows the stroke count on commits and clears outside CHOP.
    always_comb begin
        progress_d = progress_q;
        if (state_d != ANIM_CHOP) begin
            progress_d = 4'd0;
        end else if (commit_s) begin
            progress_d = stroke_progress(stroke_cnt_d);
        end else begin
            progress_d = progress_q;
        end
    end

    // Progress register.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            progress_q <= 4'd0;
        end else begin
            progress_q <= progress_d;
        end
    end

    assign chop_progress_out = progress_q;
`endif

endmodule

// File: tb/tb_player_anim_ctrl.sv
// Self-checking bench for player_anim_ctrl: directed frame/chop/spray/direction
// scenarios followed by randomized traffic against a frame-level reference model.
module tb_player_anim_ctrl;

    localparam int F  = 2;
    localparam int S  = 2;
    localparam int CL = 768;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        mv;
    logic [1:0]  md;
    logic [3:0]  held;
    logic        chop;
    logic        spray;
    logic [1:0]  player_direction_out;
    logic [3:0]  player_state_out;
    logic        chop_done_out;
    logic        frame_commit_out;
`ifdef PLAYER_ANIM_CHOP_PROGRESS_EN
    logic [3:0]  chop_progress_out;
`endif

    always #5 clk = ~clk;

    player_anim_ctrl #(
        .CHOP_FRAMES  (F),
        .CHOP_STROKES (S),
        .COMMIT_LINE  (CL)
    ) dut (
        .pixel_clk_in         (clk),
        .rst_n_in             (rst_n),
        .hcount_in            (hcount),
        .vcount_in            (vcount),
        .move_valid_in        (mv),
        .move_dir_in          (md),
        .held_item_in         (held),
        .chop_req_in          (chop),
        .spray_in             (spray),
        .player_direction_out (player_direction_out),
        .player_state_out     (player_state_out),
        .chop_done_out        (chop_done_out),
        .frame_commit_out     (frame_commit_out)
`ifdef PLAYER_ANIM_CHOP_PROGRESS_EN
        ,
        .chop_progress_out    (chop_progress_out)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Pending stimulus, applied to the DUT at the next falling edge.
    logic       p_mv = 1'b0;
    logic [1:0] p_md = 2'd0;
    logic [3:0] p_held = 4'd0;
    logic       p_chop = 1'b0;
    logic       p_spray = 1'b0;

    // Reference model: mode 0 idle, 1 chop, 2 spray; m_k counts chop commits.
    int m_mode, m_k, m_code, m_dir, m_shadow, m_prog;
    int obs_state, obs_dir, done_seen, fc_seen;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int map_held(input int h);
        return (h == 0 || (h >= 2 && h <= 8)) ? h : 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_code = 0; m_dir = 3; m_shadow = 3; m_prog = 0;
    endtask

    task automatic step(input int h, input int v);
        int commit, abort, e_done, n_mode, n_k, n_code, n_dir, n_prog, hi;
        @(negedge clk);
        hcount = 11'(h);
        vcount = 10'(v);
        mv = p_mv; md = p_md; held = p_held; chop = p_chop; spray = p_spray;
        #1;
        hi = int'(p_held);
        commit = (h == 0 && v == CL) ? 1 : 0;
        abort  = (m_mode == 1 && (!p_chop || p_mv)) ? 1 : 0;
        e_done = 0; n_mode = m_mode; n_k = m_k; n_code = m_code; n_dir = m_dir; n_prog = m_prog;
        if (commit == 1) n_dir = p_mv ? int'(p_md) : m_shadow;
        if (abort == 1) begin
            n_mode = 0; n_k = 0;
            if (commit == 1) n_code = map_held(hi);
        end else if (commit == 1) begin
            case (m_mode)
                0: begin
                    n_code = map_held(hi);
                    if (p_chop && hi == 0) begin n_mode = 1; n_k = 0; end
                    else if (hi == 8 && p_spray) n_mode = 2;
                end
                1: begin
                    if (m_k + 1 == 2 * F * S) begin
                        e_done = 1; n_mode = 0; n_k = 0; n_code = map_held(hi);
                    end else begin
                        n_code = ((m_k / F) % 2 == 0) ? 1 : 0;
                        n_k = m_k + 1;
                    end
                end
                default: begin
                    n_code = 9;
                    if (!p_spray || hi != 8) n_mode = 0;
                end
            endcase
        end
        if (n_mode != 1) n_prog = 0;
        else if (commit == 1) begin
            n_prog = ((n_k / (2 * F)) * 16) / S;
            if (n_prog > 15) n_prog = 15;
        end
        chk("frame_commit", int'(frame_commit_out), commit);
        chk("chop_done", int'(chop_done_out), e_done);
        chk("state", int'(player_state_out), m_code);
        chk("direction", int'(player_direction_out), m_dir);
`ifdef PLAYER_ANIM_CHOP_PROGRESS_EN
        chk("progress", int'(chop_progress_out), m_prog);
`endif
        obs_state = int'(player_state_out);
        obs_dir   = int'(player_direction_out);
        done_seen += int'(chop_done_out);
        fc_seen   += int'(frame_commit_out);
        @(posedge clk);
        m_mode = n_mode; m_k = n_k; m_code = n_code; m_dir = n_dir; m_prog = n_prog;
        if (p_mv) m_shadow = int'(p_md);
    endtask

    task automatic step_nc();
        int r;
        r = int'($urandom_range(0, 3));
        if (r == 0) step(0, CL - 1);
        else if (r == 1) step(1, CL);
        else step(int'($urandom_range(1, 2047)), int'($urandom_range(0, 1023)));
    endtask

    task automatic frame();
        step(0, CL);
        repeat ($urandom_range(1, 3)) step_nc();
    endtask

    int chop_seq [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    int spray_seq [4] = '{8, 9, 9, 8};

    initial begin
        int base;
        rst_n = 1'b0;
        hcount = 11'd1; vcount = 10'd0;
        mv = 1'b0; md = 2'd0; held = 4'd0; chop = 1'b0; spray = 1'b0;
        obs_state = 0; obs_dir = 0; done_seen = 0; fc_seen = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dir", int'(player_direction_out), 3);
        chk("rst_state", int'(player_state_out), 0);
        chk("rst_done", int'(chop_done_out), 0);
        chk("rst_commit", int'(frame_commit_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            base = fc_seen;
            frame();
            chk("commit_per_frame", fc_seen - base, 1);
            chk("idle_dir", obs_dir, 3);
            chk("idle_state", obs_state, 0);
        end

        p_held = 4'd5;
        step_nc();
        step_nc();
        chk("held_midframe", obs_state, 0);
        frame();
        chk("held_commit", obs_state, 5);

        p_held = 4'd0;
        p_chop = 1'b1;
        frame();
        base = done_seen;
        for (int i = 0; i < 8; i++) begin
            frame();
            chk("chop_seq", obs_state, chop_seq[i]);
        end
        chk("chop_done_count", done_seen - base, 1);
        p_chop = 1'b0;
        frame();
        chk("after_chop", obs_state, 0);

        p_chop = 1'b1;
        frame();
        for (int i = 0; i < 3; i++) begin
            frame();
            chk("abort_seq", obs_state, chop_seq[i]);
        end
        p_chop = 1'b0;
        base = done_seen;
        step_nc();
        frame();
        chk("abort_state", obs_state, 0);
        chk("abort_no_done", done_seen - base, 0);

        p_held = 4'd8;
        p_spray = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) p_spray = 1'b0;
            frame();
            chk("spray_seq", obs_state, spray_seq[i]);
        end

        p_held = 4'd0;
        p_mv = 1'b1; p_md = 2'd0;
        step(0, CL);
        p_mv = 1'b0;
        step_nc();
        chk("dir_on_commit", obs_dir, 0);
        p_mv = 1'b1; p_md = 2'd2;
        step_nc();
        p_mv = 1'b0;
        step_nc();
        chk("dir_held_until_commit", obs_dir, 0);
        frame();
        chk("dir_commit", obs_dir, 2);

        p_chop = 1'b1;
        repeat (3) frame();
        chk("chop_before_reset", obs_state, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dir", int'(player_direction_out), 3);
        chk("async_rst_state", int'(player_state_out), 0);
        chk("async_rst_done", int'(chop_done_out), 0);
        model_reset();
        p_chop = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        frame();
        chk("post_rst_state", obs_state, 0);

        for (int i = 0; i < 2500; i++) begin
            int r;
            p_mv = ($urandom_range(0, 39) == 0);
            p_md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) p_chop = ~p_chop;
            if ($urandom_range(0, 29) == 0) p_spray = ~p_spray;
            if ($urandom_range(0, 24) == 0) begin
                r = int'($urandom_range(0, 5));
                case (r)
                    1: p_held = 4'd8;
                    2: p_held = 4'd5;
                    3: p_held = 4'd1;
                    4: p_held = 4'($urandom_range(0, 15));
                    default: p_held = 4'd0;
                endcase
            end
            if ($urandom_range(0, 3) == 0) step(0, CL);
            else step_nc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_anim_ctrl.md
Name: player_anim_ctrl

Overview:
Sequences the player_state / player_direction codes that drive one player sprite renderer.
- Turns game-logic requests (move, held item, chop, extinguisher spray) into the 4-bit state and 2-bit direction codes.
- Runs the chopping animation.
- Commits new codes only at a frame boundary, so a sprite never changes mid-frame.
- One instance per player, between game logic and the sprite renderer.

Parameters:
- CHOP_FRAMES, 8: frames per chop animation phase (CHOPPING or NOTHING pose); must be >= 1.
- CHOP_STROKES, 6: full chop strokes (CHOPPING + NOTHING pair) to finish one chop.
- COMMIT_LINE, 768: vcount value at which outputs commit (first blanking line); commit when hcount_in==0 && vcount_in==COMMIT_LINE.

Ports:
- pixel_clk_in  input  1  pixel clock; the block's only clock.
- rst_n_in  input  1  asynchronous active-low reset.
- hcount_in  input  11  current pixel x.
- vcount_in  input  10  current pixel y.
- move_valid_in  input  1  one-cycle pulse: player moved.
- move_dir_in  input  2  direction of move (0 left, 1 right, 2 up, 3 down); sampled on move_valid_in.
- held_item_in  input  4  held-item code: 0 nothing, 2 onion whole, 3 onion chopped, 4 pot empty, 5 pot soup, 6 bowl empty, 7 bowl full, 8 extinguisher.
- chop_req_in  input  1  level: player is at the board holding the chop button.
- spray_in  input  1  level: spray button held.
- player_direction_out  output  2  committed direction code.
- player_state_out  output  4  committed state code (0..9, same encoding as the sprite renderer).
- chop_done_out  output  1  one-cycle pulse when a chop completes.
- frame_commit_out  output  1  one-cycle pulse on each commit cycle.

Behaviour:
- Reset (async assert, sync release): player_direction_out=3 (down), player_state_out=0, chop_done_out=0, frame_commit_out=0, FSM=IDLE, counters=0, shadow direction=3.
- Shadow direction: updated on the cycle after move_valid_in. Committed only at the next commit.
- Commit cycle: the cycle where hcount_in==0 && vcount_in==COMMIT_LINE.
  - frame_commit_out pulses that cycle.
  - Outputs take the next-state code computed that cycle and are visible the following cycle.
  - Outputs hold between commits.
- FSM advances only on commit cycles, except the abort rule below.
- IDLE:
  - Commit code = held_item_in, mapped 8 -> EXT_OFF (8). Codes 1, 9 and 10..15 from game logic map to 0.
  - If chop_req_in && held_item_in==0: go to CHOP, phase=CHOPPING (code 1), frame_cnt=0, stroke_cnt=0.
  - Else if held_item_in==8 && spray_in: go to SPRAY.
- CHOP:
  - Commit code = 1 in the CHOPPING phase, 0 in the NOTHING phase.
  - frame_cnt increments per commit. At CHOP_FRAMES-1 it wraps to 0 and the phase toggles.
  - Each NOTHING->CHOPPING toggle increments stroke_cnt.
  - On reaching CHOP_STROKES: chop_done_out pulses on that commit cycle, FSM goes to IDLE, code = held item.
- SPRAY:
  - Commit code = 9 (EXT_ON).
  - Return to IDLE at the first commit where !spray_in or held_item_in!=8.
- Abort from CHOP: chop_req_in low or move_valid_in, at any cycle, forces IDLE immediately. Counters clear; no chop_done_out; outputs change at the next commit.
- Simultaneous events:
  - Abort and stroke completion on the same commit cycle: abort wins, no done pulse.
  - move_valid_in and commit on the same cycle: the new direction is committed.
- Reset mid-chop: everything returns to reset values; no done pulse.
- Counter widths: $clog2(CHOP_FRAMES) and $clog2(CHOP_STROKES+1), minimum 1 bit. No overflow, since compares use the full parameter values.

Optional Feature:
- Macro: PLAYER_ANIM_CHOP_PROGRESS_EN.
- Defined:
  - Adds output chop_progress_out [3:0] = stroke_cnt*16/CHOP_STROKES, saturated at 15.
  - Value updates on commit cycles and is 0 outside CHOP.
  - Drives a progress bar over the cutting board.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package overcooked_pkg holds:
  - direction localparams P_LEFT/P_RIGHT/P_UP/P_DOWN;
  - state codes P_NOTHING..P_EXT_ON as a 4-bit typedef player_state_t;
  - held-item code enum.
- Sub-module frame_commit_gen generates the commit pulse from hcount/vcount; it is shared with other sprite controllers.

Test Plan:
- Reset release, no inputs, three frames -> direction=3, state=0, frame_commit_out pulses once per frame at hcount=0, vcount=768.
- held_item_in=5 mid-frame -> state stays 0 until the next commit, then becomes 5.
- Chop, CHOP_FRAMES=2, CHOP_STROKES=2, held=0, chop_req held -> committed state sequence 1,1,0,0,1,1,0,0; chop_done_out pulses once on the 8th commit; state=0 afterwards.
- Same chop, chop_req dropped after commit 3 -> IDLE, no chop_done_out, state=0 at the next commit.
- held=8, spray_in toggled 1 for 2 frames then 0 -> states 9,9,8.
- move_valid_in with dir=0 on the commit cycle -> direction_out=0 next cycle; rst_n_in pulsed during CHOP -> all outputs return to reset values asynchronously.
